// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Front end for the combinational 8-bit ALU. Commands {op, a, b} are
// buffered in a DEPTH-entry FIFO. Each command is issued to the ALU
// inputs for one cycle, and the captured result is returned with
// status flags over a valid/ready response port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing in flight; pops the FIFO head as soon as one exists
// ISSUE   | alu_* driven with the popped command; result captured at exit
// RESPOND | rsp_* valid and held; the handshake may pop the next command

module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [7:0] i_cmd_a,
    input  logic [7:0] i_cmd_b,
    input  logic [2:0] i_cmd_op,
    output logic [7:0] o_alu_a,
    output logic [7:0] o_alu_b,
    output logic [2:0] o_alu_sel,
    input  logic [7:0] i_alu_result,
    input  logic       i_alu_cout,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_rsp_result,
    output logic       o_rsp_cout,
    output logic       o_rsp_zero,
    output logic       o_rsp_err,
    output logic [2:0] o_rsp_op,
    output logic       o_busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    logic [18:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    state_t        r_state;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [18:0]   w_head;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign o_cmd_ready = !w_full && !i_rst;
    assign w_push      = i_cmd_valid && o_cmd_ready;
    // The FSM pops from IDLE, or on the response handshake in RESPOND.
    assign w_pop       = !w_empty &&
                         ((r_state == IDLE) || ((r_state == RESPOND) && i_rsp_ready));
    assign w_head      = r_mem[r_rd_ptr];
    assign o_busy      = !w_empty || (r_state != IDLE);

    // Command storage; contents need no reset since count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_cmd_op, i_cmd_a, i_cmd_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue/respond sequencer with registered ALU and response outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            o_alu_a      <= '0;
            o_alu_b      <= '0;
            o_alu_sel    <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_cout   <= 1'b0;
            o_rsp_zero   <= 1'b0;
            o_rsp_err    <= 1'b0;
            o_rsp_op     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        o_alu_sel <= w_head[18:16];
                        o_alu_a   <= w_head[15:8];
                        o_alu_b   <= w_head[7:0];
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_rsp_result <= i_alu_result;
                    o_rsp_cout   <= i_alu_cout;
                    o_rsp_zero   <= (i_alu_result == 8'h00);
                    o_rsp_err    <= o_alu_sel[2];
                    o_rsp_op     <= o_alu_sel;
                    o_rsp_valid  <= 1'b1;
                    r_state      <= RESPOND;
                end
                RESPOND: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        if (w_pop) begin
                            o_alu_sel <= w_head[18:16];
                            o_alu_a   <= w_head[15:8];
                            o_alu_b   <= w_head[7:0];
                            r_state   <= ISSUE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side front end for the 8-bit ALU. It accepts operation commands (operands plus opcode) over a valid/ready interface and buffers them in a small command FIFO. It issues one command at a time to the ALU's operand and select inputs, captures Result/Cout, and returns each result over a valid/ready response interface with status flags. It sits between any requesting master and the combinational ALU, and it is the only driver of the ALU inputs.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at clk edge
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_op  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100–111 invalid
- alu_a  out  8  to ALU A
- alu_b  out  8  to ALU B
- alu_sel  out  3  to ALU sel
- alu_result  in  8  from ALU Result
- alu_cout  in  1  from ALU Cout
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at clk edge
- rsp_result  out  8  captured ALU result
- rsp_cout  out  1  captured ALU carry
- rsp_zero  out  1  rsp_result == 0
- rsp_err  out  1  opcode was invalid (100–111)
- rsp_op  out  3  opcode of this response
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- The FIFO holds {op, a, b} (19 bits) and has DEPTH entries. The occupancy counter is clog2(DEPTH)+1 bits wide. Read and write pointers wrap modulo DEPTH.
- cmd_ready = !full && !rst.
- A push and a pop in the same cycle leave the count unchanged.
- No push occurs while full. The pop logic never pops when empty.
- FSM states: IDLE, ISSUE, RESPOND.
  - IDLE: if the FIFO is non-empty, pop the head into the operand registers (alu_a/alu_b/alu_sel) and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: alu_* hold the popped values for the whole cycle. At the closing edge, capture alu_result, alu_cout, the zero flag, the err flag and the op into the rsp_* registers, set rsp_valid, and go to RESPOND.
  - RESPOND: hold all rsp_* outputs and alu_* outputs stable until rsp_ready.
    - On the handshake, if the FIFO is non-empty, pop the next command in the same edge, clear rsp_valid and go to ISSUE.
    - On the handshake with the FIFO empty, clear rsp_valid and go to IDLE.
- Invalid opcodes are still issued. The ALU returns 0 with carry 0, so the response has rsp_err=1, rsp_zero=1 and rsp_cout=0. The FSM does not block on an invalid opcode.
- alu_* keep their last values while in IDLE; they are not zeroed.
- The block performs no arithmetic itself. rsp_zero is computed from alu_result at capture time.

## Timing
- Reset values: rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_zero=0, rsp_err=0, rsp_op=0, alu_a=0, alu_b=0, alu_sel=0, busy=0. cmd_ready=0 while rst is high and 1 in the first cycle after reset.
- Reset mid-operation flushes the FIFO, drops the in-flight command, and returns the FSM to IDLE. No response is produced for flushed commands.
- Latency: a command accepted at edge E0 into an empty FIFO with the FSM in IDLE is popped at E1 (ISSUE during E1–E2). It is captured at E2, so rsp_valid is high after E2: two cycles from acceptance.
- Throughput: with rsp_ready held high, one response every 2 cycles.
- Capacity: DEPTH entries in the FIFO plus one in flight. With rsp_ready low, DEPTH+1 commands are accepted before cmd_ready falls.
- The response order equals the command order. No drops and no duplicates.

## Test plan
- Reset, then add A=0xF0, B=0x20 → rsp_valid two cycles after acceptance, with rsp_result=0x10, rsp_cout=1, rsp_zero=0, rsp_err=0, rsp_op=000.
- Sub A=0x05, B=0x07, then and 0xAA & 0x55, then or 0x0F | 0xF0 back-to-back with rsp_ready=1 → responses in order 0xFE/cout0, 0x00/zero1, 0xFF/zero0, spaced 2 cycles apart.
- Hold rsp_ready=0 and stream commands → exactly DEPTH+1 (5) accepted, then cmd_ready=0. rsp_* are stable across the stall. Raising rsp_ready drains all 5 responses in order, and cmd_ready returns high after the first pop.
- Invalid op 3'b101 with A=0x12, B=0x34 → rsp_result=0x00, rsp_err=1, rsp_zero=1, rsp_cout=0, rsp_op=101. The next valid command completes normally.
- Push while popping: FIFO at DEPTH-1 and a RESPOND handshake coinciding with cmd_valid → count unchanged, cmd_ready stays 1, no corruption of the head entry.
- Assert rst during ISSUE with 3 queued commands → next cycle rsp_valid=0, busy=0, FIFO empty, and no stale responses after reset is released.
